// File: rtl/ft_cmd_deframer_pkg.sv
// ft_cmd_pkg: framing constants, command codes and deframer types
package ft_cmd_pkg;
    localparam logic [7:0] CMD_PREFIX = 8'hAA;
    localparam logic [7:0] CMD_SUFFIX = 8'h55;
    localparam logic [15:0] CMD_TX_TEST = 16'hBEEF;
    localparam logic [15:0] CMD_RX_TEST = 16'hCAFE;
    localparam logic [15:0] CMD_LED = 16'h1ED0;
    typedef struct packed {
        logic [15:0] code;
        logic [31:0] data;
    } cmd_t;
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, OUT} state_t;
endpackage

// File: rtl/ft_cmd_deframer_if.sv
// ft_cmd_deframer_if: RX FIFO read port plus command valid/ready stream
interface ft_cmd_deframer_if;
    logic rxfifo_empty;
    logic rxfifo_rd;
    logic [7:0] rxfifo_data;
    logic rxfifo_valid;
    logic cmd_valid;
    logic cmd_ready;
    logic [15:0] cmd_code;
    logic [31:0] cmd_data;
    modport master (
        input rxfifo_empty, rxfifo_data, rxfifo_valid, cmd_ready,
        output rxfifo_rd, cmd_valid, cmd_code, cmd_data
    );
    modport slave (
        output rxfifo_empty, rxfifo_data, rxfifo_valid, cmd_ready,
        input rxfifo_rd, cmd_valid, cmd_code, cmd_data
    );
endinterface

// File: rtl/ft_cmd_deframer.sv
// ft_cmd_deframer: slides an 8-byte window over RX FIFO bytes and emits prefix/suffix-framed commands
module ft_cmd_deframer
    import ft_cmd_pkg::*;
#(
    parameter logic [7:0] PREFIX = CMD_PREFIX,
    parameter logic [7:0] SUFFIX = CMD_SUFFIX,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W = 16
) (
    input logic sys_clk,
    input logic sys_rst,
    ft_cmd_deframer_if.master bus,
    output logic [CNT_W-1:0] frame_cnt,
    output logic sync_err,
    output logic timeout
);
    state_t state_q, state_d;
    logic [63:0] window_q, window_d;
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic rd_q, rd_d;
    logic cmd_valid_q, cmd_valid_d;
    cmd_t cmd_q, cmd_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic sync_err_q, sync_err_d;
    logic timeout_q, timeout_d;
    logic partial, fire;
    assign partial = byte_cnt_q != 4'd0 && byte_cnt_q != 4'd8;
    assign fire = TIMEOUT_CYC != 0 && partial && tcnt_q == 32'(TIMEOUT_CYC - 1);
    always_comb begin
        state_d = state_q;
        window_d = window_q;
        byte_cnt_d = byte_cnt_q;
        tcnt_d = '0;
        rd_d = 1'b0;
        cmd_valid_d = cmd_valid_q;
        cmd_d = cmd_q;
        frame_cnt_d = frame_cnt_q;
        sync_err_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    window_d = '0;
                    byte_cnt_d = '0;
                    timeout_d = 1'b1;
                end else if (!bus.rxfifo_empty) begin
                    rd_d = 1'b1;
                    state_d = WAIT;
                end else if (partial) begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            WAIT: begin
                if (bus.rxfifo_valid) begin
                    window_d = {bus.rxfifo_data, window_q[63:8]};
                    byte_cnt_d = byte_cnt_q == 4'd8 ? 4'd8 : byte_cnt_q + 4'd1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (byte_cnt_q == 4'd8 && window_q[63:56] == PREFIX && window_q[7:0] == SUFFIX) begin
                    cmd_d = '{code: window_q[55:40], data: window_q[39:8]};
                    cmd_valid_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    window_d = '0;
                    byte_cnt_d = '0;
                    state_d = OUT;
                end else begin
                    // a failed full window is kept so the next byte retries one position on
                    sync_err_d = byte_cnt_q == 4'd8;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            window_q <= '0;
            byte_cnt_q <= '0;
            tcnt_q <= '0;
            rd_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q <= '0;
            frame_cnt_q <= '0;
            sync_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            window_q <= window_d;
            byte_cnt_q <= byte_cnt_d;
            tcnt_q <= tcnt_d;
            rd_q <= rd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q <= cmd_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q <= sync_err_d;
            timeout_q <= timeout_d;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (!sys_rst)
            assert (!(bus.rxfifo_valid && state_q != WAIT));
    end
    assign bus.rxfifo_rd = rd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_code = cmd_q.code;
    assign bus.cmd_data = cmd_q.data;
    assign frame_cnt = frame_cnt_q;
    assign sync_err = sync_err_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_ft_cmd_deframer.sv
// tb_ft_cmd_deframer: directed scenarios against a byte FIFO model with configurable read latency
module tb_ft_cmd_deframer;
    import ft_cmd_pkg::*;
    logic sys_clk = 1'b0;
    logic sys_rst;
    logic [15:0] frame_cnt;
    logic sync_err, timeout;
    ft_cmd_deframer_if bus();
    ft_cmd_deframer #(.TIMEOUT_CYC(100)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus),
        .frame_cnt(frame_cnt),
        .sync_err(sync_err),
        .timeout(timeout)
    );
    always #5 sys_clk = ~sys_clk;
    int total = 0, bad = 0;
    int cyc = 0, last_v = 0, to_cyc = 0, n_sync = 0, n_to = 0, lat = 1, gi = 0;
    logic prev_cv = 1'b0;
    logic [7:0] fq[$];
    logic [7:0] mb;
    logic [47:0] got[$];
    logic [15:0] got_cnt[$];
    int lats[$];
    task automatic chk(string tag, logic [63:0] seen, logic [63:0] want);
        total++;
        if (seen !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, seen, want);
        end
    endtask
    task automatic push_frame(logic [15:0] code, logic [31:0] data);
        fq.push_back(CMD_SUFFIX);
        for (int i = 0; i < 4; i++) fq.push_back(data[8*i +: 8]);
        fq.push_back(code[7:0]);
        fq.push_back(code[15:8]);
        fq.push_back(CMD_PREFIX);
    endtask
    task automatic wait_cmds(int n, int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge sys_clk);
            k++;
        end
        chk($sformatf("wait_cmd%0d", n), 64'(got.size() >= n), 1);
    endtask
    task automatic check_cmd(string tag, logic [15:0] code, logic [31:0] data, logic [15:0] cnt);
        if (gi < got.size()) begin
            chk({tag, "_code"}, got[gi][47:32], code);
            chk({tag, "_data"}, got[gi][31:0], data);
            chk({tag, "_cnt"}, got_cnt[gi], cnt);
            chk({tag, "_lat"}, lats[gi], 2);
        end else begin
            chk({tag, "_present"}, 0, 1);
        end
        gi++;
    endtask
    always @(posedge sys_clk) cyc++;
    always @(negedge sys_clk) begin
        if (bus.rxfifo_valid) last_v = cyc;
        if (bus.cmd_valid && !prev_cv) lats.push_back(cyc - last_v);
        prev_cv = bus.cmd_valid;
        if (bus.cmd_valid && bus.cmd_ready) begin
            got.push_back({bus.cmd_code, bus.cmd_data});
            got_cnt.push_back(frame_cnt);
        end
        if (sync_err) n_sync++;
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
        end
    end
    initial begin
        bus.rxfifo_valid = 1'b0;
        bus.rxfifo_data = 8'h00;
        bus.rxfifo_empty = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (bus.rxfifo_rd && fq.size() > 0) begin
                mb = fq.pop_front();
                bus.rxfifo_empty = fq.size() == 0;
                repeat (lat) @(posedge sys_clk);
                #1 bus.rxfifo_valid = 1'b1;
                bus.rxfifo_data = mb;
                @(posedge sys_clk);
                #1 bus.rxfifo_valid = 1'b0;
            end else begin
                bus.rxfifo_empty = fq.size() == 0;
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int s_sync, s_to, rd_seen, changes;
        logic [15:0] hold_code;
        logic [31:0] hold_data;
        sys_rst = 1'b1;
        bus.cmd_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_rd", bus.rxfifo_rd, 0);
        chk("rst_valid", bus.cmd_valid, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_flags", {sync_err, timeout}, 0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        // good frame
        s_sync = n_sync;
        push_frame(CMD_TX_TEST, 32'h0000_0100);
        wait_cmds(1, 200);
        check_cmd("good", CMD_TX_TEST, 32'h0000_0100, 16'd1);
        chk("good_sync", n_sync - s_sync, 0);
        // garbage byte then a frame: one sync error, then a decode on byte 9
        s_sync = n_sync;
        fq.push_back(8'h13);
        push_frame(CMD_TX_TEST, 32'h0000_0100);
        wait_cmds(2, 300);
        repeat (5) @(posedge sys_clk);
        chk("resync_ncmd", got.size(), 2);
        chk("resync_sync", n_sync - s_sync, 1);
        check_cmd("resync", CMD_TX_TEST, 32'h0000_0100, 16'd2);
        // backpressure with a second frame queued
        bus.cmd_ready = 1'b0;
        push_frame(CMD_LED, 32'h0000_0001);
        push_frame(CMD_RX_TEST, 32'h1234_5678);
        for (int k = 0; k < 200 && !bus.cmd_valid; k++) @(negedge sys_clk);
        chk("bp_valid", bus.cmd_valid, 1);
        hold_code = bus.cmd_code;
        hold_data = bus.cmd_data;
        chk("bp_code", hold_code, CMD_LED);
        chk("bp_data", hold_data, 32'h1);
        rd_seen = 0;
        changes = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (bus.rxfifo_rd) rd_seen++;
            if (!bus.cmd_valid || bus.cmd_code != hold_code || bus.cmd_data != hold_data) changes++;
        end
        chk("bp_rd", rd_seen, 0);
        chk("bp_stable", changes, 0);
        @(posedge sys_clk);
        #1 bus.cmd_ready = 1'b1;
        wait_cmds(4, 300);
        check_cmd("bp_first", CMD_LED, 32'h1, 16'd3);
        check_cmd("bp_second", CMD_RX_TEST, 32'h1234_5678, 16'd4);
        // partial frame timeout
        s_sync = n_sync;
        s_to = n_to;
        fq.push_back(8'h55);
        fq.push_back(8'h00);
        fq.push_back(8'h01);
        repeat (140) @(posedge sys_clk);
        chk("to_count", n_to - s_to, 1);
        chk("to_cycle", to_cyc - last_v, 102);
        push_frame(CMD_LED, 32'h0000_0002);
        wait_cmds(5, 200);
        check_cmd("after_to", CMD_LED, 32'h2, 16'd5);
        chk("to_sync", n_sync - s_sync, 0);
        // reset after byte 5
        for (int i = 0; i < 5; i++) fq.push_back(i == 0 ? 8'h55 : i == 1 ? 8'h01 : 8'h00);
        repeat (60) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("mrst_cnt", frame_cnt, 0);
        chk("mrst_cmd", {bus.cmd_valid, bus.cmd_code, bus.cmd_data}, 0);
        chk("mrst_misc", {bus.rxfifo_rd, sync_err, timeout}, 0);
        push_frame(CMD_RX_TEST, 32'hDEAD_BEEF);
        wait_cmds(6, 200);
        check_cmd("after_rst", CMD_RX_TEST, 32'hDEAD_BEEF, 16'd1);
        // back-to-back frames, read latency 3
        s_sync = n_sync;
        lat = 3;
        push_frame(CMD_TX_TEST, 32'h1122_3344);
        push_frame(CMD_LED, 32'h0000_ABCD);
        wait_cmds(8, 400);
        check_cmd("b2b_first", CMD_TX_TEST, 32'h1122_3344, 16'd2);
        check_cmd("b2b_second", CMD_LED, 32'h0000_ABCD, 16'd3);
        chk("b2b_sync", n_sync - s_sync, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ft_cmd_deframer.md
Name: ft_cmd_deframer

Overview:
Command deframer between the FT245 master's RX FIFO read port and the command/test FSM, all in the sys_clk domain. Pops bytes from the RX FIFO one at a time and keeps a sliding 8-byte window. When the window holds a valid prefix/suffix frame, it emits {code, data} on a valid/ready interface. Resynchronises byte-by-byte after garbage and discards stalled partial frames after a timeout.

Parameters:
PREFIX, 8'hAA, required value of the last wire byte
SUFFIX, 8'h55, required value of the first wire byte
TIMEOUT_CYC, 1_000_000, idle cycles before a partial frame is dropped (0 = disabled)
CNT_W, 16, width of frame_cnt

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
rxfifo_empty  in  1  RX FIFO empty flag
rxfifo_rd  out  1  RX FIFO read strobe, registered, 1-cycle pulse
rxfifo_data  in  8  RX FIFO read data, qualified by rxfifo_valid
rxfifo_valid  in  1  read data valid; arrives L>=1 cycles after rxfifo_rd
cmd_valid  out  1  command available
cmd_ready  in  1  consumer accepts command
cmd_code  out  16  command code
cmd_data  out  32  command argument
frame_cnt  out  CNT_W  count of good frames emitted, wraps
sync_err  out  1  1-cycle pulse: full window failed the framing check
timeout  out  1  1-cycle pulse: partial frame dropped

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset values: all outputs 0, window 0, byte_cnt 0, state IDLE, timeout counter 0. A reset mid-frame discards the partial window and any pending command.
- Window update: on each accepted byte, window <= {rxfifo_data, window[63:8]}. byte_cnt increments and saturates at 8.
- Frame layout: W = {b7..b0}, where b0 is first on the wire. Prefix = W[63:56], code = W[55:40], data = W[39:8], suffix = W[7:0]. Multi-byte fields are sent LSB first.
- Outstanding reads: at most one read in flight. No read is issued while cmd_valid=1; this is the backpressure path.
- FSM state IDLE:
  - If the timeout fires (see below), clear and stay; no read that cycle.
  - Else if !rxfifo_empty, set rxfifo_rd=1 for one cycle and go to WAIT.
- FSM state WAIT: rxfifo_rd=0. On rxfifo_valid, shift the window and go to CHECK.
- FSM state CHECK, after the update:
  - If byte_cnt==8 and prefix==PREFIX and suffix==SUFFIX: latch cmd_code and cmd_data, set cmd_valid=1, increment frame_cnt, clear window and byte_cnt, go to OUT.
  - Else if byte_cnt==8: pulse sync_err, keep the window (the next byte slides it by one), go to IDLE.
  - Else go to IDLE.
- FSM state OUT: hold cmd_* stable while cmd_valid && !cmd_ready. On cmd_valid && cmd_ready, cmd_valid=0 next cycle and go to IDLE. If cmd_ready is already high on entry, this is a 1-cycle transfer.
- Latency: last byte's rxfifo_valid at cycle t gives cmd_valid=1 at t+2.
- Timeout:
  - The counter runs while byte_cnt is in 1..7 and the state is IDLE.
  - It resets on every accepted byte and whenever byte_cnt==0.
  - On reaching TIMEOUT_CYC: clear window and byte_cnt, pulse timeout, counter back to 0.
  - Never active in WAIT or OUT.
- rxfifo_valid outside WAIT is ignored and flagged by a simulation assertion.
- frame_cnt wraps from all-ones to 0.

Decomposition:
- Package ft_cmd_pkg:
  - constants CMD_PREFIX 8'hAA and CMD_SUFFIX 8'h55;
  - command codes CMD_TX_TEST 16'hBEEF, CMD_RX_TEST 16'hCAFE, CMD_LED 16'h1ED0;
  - typedef cmd_t {code[15:0], data[31:0]};
  - deframer state enum {IDLE, WAIT, CHECK, OUT}.
- No sub-module. The timeout counter is inline.

Test Plan:
1. Good frame. Feed 55 00 01 00 00 EF BE AA, with rxfifo_valid 1 cycle after each rd and cmd_ready=1 -> one cmd_valid pulse, code=16'hBEEF, data=32'h00000100, frame_cnt=1, no sync_err.
2. Resync. Feed 13 then the frame from scenario 1 -> no command after byte 8 (garbage in the window), exactly one sync_err pulse, then a correct command after byte 9.
3. Backpressure. Hold cmd_ready=0 for 20 cycles, with a good 1ED0 frame (data=1) followed by a second good frame queued in the FIFO.
   - Expected: cmd_* stays stable and rxfifo_rd stays 0 throughout.
   - After cmd_ready=1: the first command transfers, then the second command follows.
4. Timeout. With TIMEOUT_CYC=100, feed 3 bytes then leave the FIFO empty for 120 cycles -> timeout pulses at cycle 100 of idle. The following full good frame decodes with no sync_err.
5. Reset mid-frame. Assert sys_rst for 1 cycle after byte 5 -> all outputs 0 next cycle. The following 8-byte good frame decodes correctly.
6. Back-to-back frames. Stream 2 frames with no FIFO gaps and read latency L=3 -> 2 commands, frame_cnt=2, each cmd_valid 2 cycles after its last rxfifo_valid.
